// File: rtl/spike_rate_encoder.sv
// Converts an intensity value into an evenly spaced spike train over a WINDOW-cycle window.
// Spike placement uses accumulate-and-subtract, so a window carries min(value, WINDOW) spikes.
module spike_rate_encoder #(
  parameter int unsigned VAL_W  = 5,
  parameter int unsigned WINDOW = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [VAL_W-1:0]                 in_value,
  input  logic                             abort,
  output logic                             spike_out,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(WINDOW+1)-1:0]      spike_count
);

  localparam int unsigned CW = $clog2(WINDOW + 1);
  localparam int unsigned AW = $clog2(2 * WINDOW);
  localparam int unsigned EW = (VAL_W > CW) ? VAL_W : CW;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          r_state;
  logic [CW-1:0]   r_val;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_slot;
  logic [CW-1:0]   r_count;
  logic            r_spike;
  logic            r_busy;
  logic            r_done;

  state_e          w_state_nxt;
  logic [CW-1:0]   w_val_nxt;
  logic [AW-1:0]   w_acc_nxt;
  logic [CW-1:0]   w_slot_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_spike_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  logic [EW-1:0]   w_in_ext;
  logic [CW-1:0]   w_val_sat;
  logic [AW-1:0]   w_sum;

  assign w_in_ext  = EW'(in_value);
  assign w_val_sat = (w_in_ext > EW'(WINDOW)) ? CW'(WINDOW) : CW'(w_in_ext);
  // acc < WINDOW and val <= WINDOW, so the sum stays below 2*WINDOW and fits AW bits.
  assign w_sum     = r_acc + AW'(r_val);

  always_comb begin
    w_state_nxt = r_state;
    w_val_nxt   = r_val;
    w_acc_nxt   = r_acc;
    w_slot_nxt  = r_slot;
    w_count_nxt = r_count;
    w_spike_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_busy_nxt = 1'b0;
        if (in_valid) begin
          w_state_nxt = StRun;
          w_val_nxt   = w_val_sat;
          w_acc_nxt   = '0;
          w_slot_nxt  = '0;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          // Abort beats a coincident final slot: no spike, no done.
          w_state_nxt = StIdle;
          w_busy_nxt  = 1'b0;
        end else begin
          if (w_sum >= AW'(WINDOW)) begin
            w_spike_nxt = 1'b1;
            w_acc_nxt   = w_sum - AW'(WINDOW);
            w_count_nxt = r_count + CW'(1);
          end else begin
            w_acc_nxt   = w_sum;
          end
          w_slot_nxt = r_slot + CW'(1);
          if (r_slot == CW'(WINDOW - 1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_val   <= '0;
      r_acc   <= '0;
      r_slot  <= '0;
      r_count <= '0;
      r_spike <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_val   <= w_val_nxt;
      r_acc   <= w_acc_nxt;
      r_slot  <= w_slot_nxt;
      r_count <= w_count_nxt;
      r_spike <= w_spike_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign in_ready    = (r_state == StIdle);
  assign spike_out   = r_spike;
  assign busy        = r_busy;
  assign done        = r_done;
  assign spike_count = r_count;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: floor-formula window model checked every cycle, plus
// literal spike masks and counts for the directed scenarios.
module tb_spike_rate_encoder;

  localparam int unsigned VAL_W  = 5;
  localparam int unsigned WINDOW = 16;
  localparam int unsigned CW     = $clog2(WINDOW + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [VAL_W-1:0] in_value;
  logic             abort;
  logic             spike_out;
  logic             busy;
  logic             done;
  logic [CW-1:0]    spike_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  spike_rate_encoder #(.VAL_W(VAL_W), .WINDOW(WINDOW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .abort      (abort),
    .spike_out  (spike_out),
    .busy       (busy),
    .done       (done),
    .spike_count(spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Window model: slot k of a window with value v spikes iff floor(k*v/W) steps up,
  // and the running count after slot k is floor(k*v/W).
  bit m_active = 0;
  int m_k      = 0;
  int m_v      = 0;
  int m_spike  = 0;
  int m_busy   = 0;
  int m_done   = 0;
  int m_count  = 0;

  always @(posedge clk) begin : model
    int kk;
    if (rst) begin
      m_active <= 0;
      m_spike  <= 0;
      m_busy   <= 0;
      m_done   <= 0;
      m_count  <= 0;
    end else if (m_active) begin
      if (abort) begin
        m_active <= 0;
        m_spike  <= 0;
        m_busy   <= 0;
        m_done   <= 0;
      end else begin
        kk = m_k + 1;
        m_k     <= kk;
        m_spike <= ((kk * m_v) / WINDOW > ((kk - 1) * m_v) / WINDOW) ? 1 : 0;
        m_count <= (kk * m_v) / WINDOW;
        m_done  <= (kk == WINDOW) ? 1 : 0;
        m_busy  <= (kk < WINDOW) ? 1 : 0;
        if (kk == WINDOW) m_active <= 0;
      end
    end else begin
      m_spike <= 0;
      m_done  <= 0;
      m_busy  <= 0;
      if (in_valid) begin
        m_active <= 1;
        m_k      <= 0;
        m_v      <= (int'(in_value) > WINDOW) ? WINDOW : int'(in_value);
        m_count  <= 0;
        m_busy   <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("spike_out", int'(spike_out), m_spike);
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
      chk("spike_count", int'(spike_count), m_count);
      chk("in_ready", int'(in_ready), m_active ? 0 : 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer v, then collect the 16 slot spikes as a mask (bit k-1 = slot k).
  task automatic run_window(input int v, output logic [15:0] mask, output int cnt);
    in_value = VAL_W'(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mask = '0;
    cnt  = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      mask[k] = spike_out;
      if (k == 15) begin
        chk("done_at_last_slot", int'(done), 1);
        chk("ready_at_last_slot", int'(in_ready), 1);
        cnt = int'(spike_count);
      end
    end
  endtask

  initial begin
    logic [15:0] mask;
    int          cnt;
    int          waited;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    abort    = 1'b0;
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(spike_count), 0);
    chk("reset_ready", int'(in_ready), 1);

    // Scenario 1-3: basic patterns and saturation
    run_window(4, mask, cnt);
    chk("v4_mask", int'(mask), 16'h8888);
    chk("v4_count", cnt, 4);
    run_window(5, mask, cnt);
    chk("v5_mask", int'(mask), 16'h9248);
    chk("v5_count", cnt, 5);
    run_window(0, mask, cnt);
    chk("v0_mask", int'(mask), 0);
    chk("v0_count", cnt, 0);
    run_window(20, mask, cnt);
    chk("v20_mask", int'(mask), 16'hFFFF);
    chk("v20_count", cnt, 16);
    tick();
    chk("count_holds", int'(spike_count), 16);

    // Scenario 4: held in_valid during RUN is not consumed
    in_value = VAL_W'(8);
    in_valid = 1'b1;
    tick();
    in_value = VAL_W'(2);
    waited = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      waited = i;
      if (in_ready) break;
    end
    chk("held_wait_slots", waited, 16);
    chk("held_first_count", int'(spike_count), 8);
    tick();
    in_valid = 1'b0;
    chk("gap_spike", int'(spike_out), 0);
    chk("gap_busy", int'(busy), 1);
    mask = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      mask[k] = spike_out;
    end
    chk("v2_mask", int'(mask), 16'h8080);
    chk("v2_count", int'(spike_count), 2);

    // Scenario 5: abort at slot 6 edge, then abort in IDLE
    tick();
    in_value = VAL_W'(8);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_count", int'(spike_count), 2);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(in_ready), 1);
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    chk("idle_abort_count", int'(spike_count), 2);
    chk("idle_abort_ready", int'(in_ready), 1);

    // Scenario 6: reset mid-window, then a clean window
    in_value = VAL_W'(16);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_count", int'(spike_count), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_count", int'(spike_count), 0);
    chk("rst_mid_spike", int'(spike_out), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(in_ready), 1);
    run_window(4, mask, cnt);
    chk("post_rst_mask", int'(mask), 16'h8888);
    chk("post_rst_count", cnt, 4);
    tick();
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
